mac: RTL and testbench

Streaming multiply-accumulate engine. After a `start` pulse it accepts one (data, weight) pair per clock while `tready_s` is high, accumulates the products, and presents the final sum when the beat flagged `tlast_s` is consumed. It sits downstream of the authentication stage: `start` is only issued once authentication has completed.

---
 rtl/mac_pkg.sv | 13 +
 rtl/mac_datapath.sv | 51 +++++
 rtl/mac.sv | 88 ++++++++
 tb/tb_mac.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the streaming multiply-accumulate engine.
// No logic here: state encoding and default operand width only.
// Imported by the datapath and the top-level controller.
package mac_pkg;

    localparam int MAC_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mac_datapath.sv
// Multiplier, accumulator register and result register of the MAC engine.
// Latency: product lands in the accumulator/result on the edge of the beat.
// No backpressure: every cycle with acc_en high consumes the operands.
module mac_datapath
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 acc_en,
    input  logic                 last,
    input  logic [WIDTH-1:0]     tdata,
    input  logic [WIDTH-1:0]     weight,
    output logic [2*WIDTH-1:0]   result
);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_result;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_sum;

    // Zero-extend both operands so the product is a full unsigned 2*WIDTH value.
    assign w_prod = {{WIDTH{1'b0}}, tdata} * {{WIDTH{1'b0}}, weight};
    // Running sum wraps naturally at 2*WIDTH bits.
    assign w_sum  = r_acc + w_prod;

    // Accumulator: cleared at stream start, adds one product per consumed beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clear) begin
            r_acc <= '0;
        end else if (acc_en) begin
            r_acc <= w_sum;
        end
    end

    // Result captures the sum including the final beat and holds until the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result <= '0;
        end else if (acc_en && last) begin
            r_result <= w_sum;
        end
    end

    assign result = r_result;

endmodule

// File: rtl/mac.sv
// Streaming MAC: start -> accept one (data, weight) beat per clock -> result on tlast.
// Latency: result/done registered on the tlast beat edge; tready one cycle after start.
// No valid/backpressure: every cycle with tready_s high consumes a beat.
module mac
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 tlast_s,
    output logic                 tready_s,
    input  logic [WIDTH-1:0]     tdata_s,
    input  logic [WIDTH-1:0]     weight_s,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done
);

    state_t r_state;
    state_t w_next;
    logic   r_tready;
    logic   r_done;
    logic   w_clear;
    logic   w_acc_en;
    logic   w_last;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and datapath controls; tlast_s in IDLE and start in RUN are don't-cares.
    always_comb begin
        w_next   = r_state;
        w_clear  = 1'b0;
        w_acc_en = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_clear = 1'b1;
                    w_next  = RUN;
                end
            end
            RUN: begin
                w_acc_en = 1'b1;
                if (tlast_s) begin
                    w_last = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Registered handshake outputs: tready follows the next state, done pulses after the last beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tready <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_tready <= (w_next == RUN);
            r_done   <= w_last;
        end
    end

    assign tready_s = r_tready;
    assign done     = r_done;

    mac_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_clear),
        .acc_en (w_acc_en),
        .last   (w_last),
        .tdata  (tdata_s),
        .weight (weight_s),
        .result (result)
    );

endmodule

// File: tb/tb_mac.sv
// Self-checking bench for mac: directed sequence with random operands.
// Reference: running modulo-2^64 sum of products, kept as plain arithmetic.
// Outputs are sampled 1 time unit after each rising edge.
module tb_mac;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        tlast_s;
    logic        tready_s;
    logic [31:0] tdata_s;
    logic [31:0] weight_s;
    logic [63:0] result;
    logic        done;

    int          n_checks;
    int          n_fail;
    logic [63:0] model_acc;
    logic [63:0] exp_result;

    mac #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .tlast_s  (tlast_s),
        .tready_s (tready_s),
        .tdata_s  (tdata_s),
        .weight_s (weight_s),
        .result   (result),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle to the sampling point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; the model's running sum restarts at zero.
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        model_acc = '0;
    endtask

    // Drive one beat across one edge and fold it into the model.
    task automatic beat(input logic [31:0] d, input logic [31:0] w, input logic last);
        logic [63:0] prod;
        tdata_s  = d;
        weight_s = w;
        tlast_s  = last;
        step();
        tlast_s  = 1'b0;
        prod = 64'(d) * 64'(w);
        model_acc = model_acc + prod;
        if (last) exp_result = model_acc;
    endtask

    task automatic check_done(input string tag);
        check({tag, ".result"}, result, exp_result);
        check({tag, ".done"}, 64'(done), 64'd1);
        check({tag, ".tready"}, 64'(tready_s), 64'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] w;
        n_checks   = 0;
        n_fail     = 0;
        model_acc  = '0;
        exp_result = '0;
        rst_n      = 1'b0;
        start      = 1'b0;
        tlast_s    = 1'b0;
        tdata_s    = '0;
        weight_s   = '0;
        step();
        step();
        check("reset.tready", 64'(tready_s), 64'd0);
        check("reset.result", result, 64'd0);
        check("reset.done", 64'(done), 64'd0);
        rst_n = 1'b1;
        step();

        // Basic stream: 20 random beats, even beats with negative data.
        do_start();
        check("basic.tready_after_start", 64'(tready_s), 64'd1);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) d = 32'd0 - 32'($urandom_range(1, 100000));
            else            d = $urandom;
            w = $urandom;
            beat(d, w, i == 19);
            if (i == 10) begin
                check("basic.mid_done", 64'(done), 64'd0);
                check("basic.mid_tready", 64'(tready_s), 64'd1);
            end
        end
        check_done("basic");
        step();
        check("basic.done_falls", 64'(done), 64'd0);
        check("basic.result_held", result, exp_result);

        // Single beat.
        do_start();
        beat(32'd7, 32'd6, 1'b1);
        check("single.result", result, 64'd42);
        check_done("single");
        step();
        check("single.done_one_cycle", 64'(done), 64'd0);

        // Wrap-around.
        do_start();
        beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("wrap.result", result, 64'hFFFF_FFFC_0000_0002);
        check_done("wrap");
        step();

        // Back-to-back streams with start at the earliest restart edge.
        do_start();
        beat(32'd3, 32'd4, 1'b0);
        beat(32'd5, 32'd5, 1'b1);
        check("b2b.first", result, 64'd37);
        check_done("b2b1");
        do_start();
        check("b2b.restart_tready", 64'(tready_s), 64'd1);
        check("b2b.result_kept", result, 64'd37);
        check("b2b.done_low", 64'(done), 64'd0);
        beat(32'd2, 32'd2, 1'b1);
        check("b2b.second", result, 64'd4);
        check_done("b2b2");
        step();

        // Reset mid-stream.
        do_start();
        for (int i = 0; i < 3; i++) beat($urandom, $urandom, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_result = '0;
        check("rst.tready", 64'(tready_s), 64'd0);
        check("rst.result", result, 64'd0);
        check("rst.done", 64'(done), 64'd0);
        do_start();
        beat(32'd1, 32'd9, 1'b1);
        check("rst.after", result, 64'd9);
        check_done("rst");
        step();

        // Ignored inputs: tlast/data in IDLE, start in RUN, start+tlast together in IDLE.
        for (int i = 0; i < 3; i++) begin
            tdata_s  = $urandom;
            weight_s = $urandom;
            tlast_s  = 1'b1;
            step();
            check("ign.idle_result", result, exp_result);
            check("ign.idle_done", 64'(done), 64'd0);
            check("ign.idle_tready", 64'(tready_s), 64'd0);
        end
        tlast_s = 1'b1;
        do_start();
        tlast_s = 1'b0;
        check("ign.start_tlast_tready", 64'(tready_s), 64'd1);
        check("ign.start_tlast_done", 64'(done), 64'd0);
        start = 1'b1;
        for (int i = 0; i < 4; i++) beat($urandom, $urandom, 1'b0);
        start = 1'b0;
        beat($urandom, $urandom, 1'b1);
        check_done("ign.run");
        step();
        check("ign.final_idle", 64'(tready_s), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
